// File: rtl/renode_irq_latch_if.sv
// rtl/renode_irq_latch_if.sv - AXI4-Lite control port bundle for renode_irq_latch
interface renode_irq_latch_if #(
  parameter int AddrWidth = 12
);
  logic [AddrWidth-1:0] awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [AddrWidth-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/renode_irq_latch.sv
// rtl/renode_irq_latch.sv - sticky maskable interrupt latch with AXI4-Lite control
module renode_irq_latch #(
  parameter int SourceCount  = 2,
  parameter int AddrWidth    = 12,
  parameter int CounterWidth = 8
) (
  input  logic                   clk,
  input  logic                   areset_n,
  input  logic [SourceCount-1:0] irq_src,
  output logic [SourceCount-1:0] irq_out,
  renode_irq_latch_if.slave      axi
);

  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam int unsigned NumWords   = 4 + SourceCount;

  logic [SourceCount-1:0]  src_q, status_q, status_d, enable_q, enable_d, mode_q, mode_d;
  logic [SourceCount-1:0]  irq_out_q, rise, event_hit, w1c;
  logic [CounterWidth-1:0] cnt_q [SourceCount];
  logic [CounterWidth-1:0] cnt_d [SourceCount];

  logic                 aw_full_q, w_full_q, bvalid_q, rvalid_q;
  logic [AddrWidth-3:0] aw_addr_q;
  logic [31:0]          w_data_q, rdata_q, rd_data, wmask;
  logic [3:0]           w_strb_q;
  logic [1:0]           bresp_q, rresp_q, rd_resp;
  logic                 aw_hs, w_hs, ar_hs, commit, wr_err;
  int unsigned          wr_idx, rd_idx;
  logic                 unused_bits;

  // A rising edge is counted in both modes; only the STATUS set source differs.
  assign rise      = irq_src & ~src_q;
  assign event_hit = (irq_src & mode_q) | (rise & ~mode_q);

  assign axi.awready = areset_n & ~aw_full_q;
  assign axi.wready  = areset_n & ~w_full_q;
  assign axi.arready = areset_n & ~rvalid_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign irq_out     = irq_out_q;

  assign aw_hs  = axi.awvalid & axi.awready;
  assign w_hs   = axi.wvalid & axi.wready;
  assign ar_hs  = axi.arvalid & axi.arready;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  assign wr_idx = 32'(aw_addr_q);
  assign rd_idx = 32'(axi.araddr[AddrWidth-1:2]);
  assign wmask  = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
  assign wr_err = (wr_idx >= NumWords) || (wr_idx == 32'd2);

  assign unused_bits = ^{axi.araddr[1:0], axi.awaddr[1:0], w_data_q[31:SourceCount],
                         wmask[31:SourceCount]};

  always_comb begin
    w1c      = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    if (commit && wr_idx == 32'd0) begin
      w1c = w_data_q[SourceCount-1:0] & wmask[SourceCount-1:0];
    end
    if (commit && wr_idx == 32'd1) begin
      enable_d = (enable_q & ~wmask[SourceCount-1:0]) |
                 (w_data_q[SourceCount-1:0] & wmask[SourceCount-1:0]);
    end
    if (commit && wr_idx == 32'd3) begin
      mode_d = (mode_q & ~wmask[SourceCount-1:0]) |
               (w_data_q[SourceCount-1:0] & wmask[SourceCount-1:0]);
    end
    // A new event beats a same-cycle clear.
    status_d = (status_q & ~w1c) | event_hit;
  end

  always_comb begin
    for (int i = 0; i < SourceCount; i++) begin
      if (commit && wr_idx == 32'(4 + i)) begin
        cnt_d[i] = CounterWidth'(rise[i]);
      end else if (rise[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CounterWidth'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    if (rd_idx >= NumWords) begin
      rd_resp = RespSlvErr;
    end else if (rd_idx == 32'd0) begin
      rd_data = 32'(status_q);
    end else if (rd_idx == 32'd1) begin
      rd_data = 32'(enable_q);
    end else if (rd_idx == 32'd2) begin
      rd_data = 32'(status_q & enable_q);
    end else if (rd_idx == 32'd3) begin
      rd_data = 32'(mode_q);
    end else begin
      for (int i = 0; i < SourceCount; i++) begin
        if (rd_idx == 32'(4 + i)) begin
          rd_data = 32'(cnt_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      src_q     <= '0;
      status_q  <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      irq_out_q <= '0;
      cnt_q     <= '{default: '0};
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      src_q     <= irq_src;
      status_q  <= status_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_out_q <= status_q & enable_q;
      cnt_q     <= cnt_d;

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RespSlvErr : RespOkay;
      end else if (bvalid_q && axi.bready) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi.awaddr[AddrWidth-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_renode_irq_latch.sv
// tb/tb_renode_irq_latch.sv - scoreboard bench for renode_irq_latch
module tb_renode_irq_latch;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [1:0] irq_src = '0;
  logic [1:0] irq_out;
  int         checks = 0;
  int         errors = 0;

  logic [1:0]  b_exp [$];
  logic [45:0] r_exp [$];

  renode_irq_latch_if #(.AddrWidth(12)) bus ();

  renode_irq_latch #(.SourceCount(2), .AddrWidth(12), .CounterWidth(8)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .irq_src  (irq_src),
    .irq_out  (irq_out),
    .axi      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=response", name);
  endtask

  // Monitor: pops the expected response whenever a handshake is about to complete.
  always @(negedge clk) begin
    if (bus.bvalid && bus.bready) begin
      if (b_exp.size() == 0) begin
        timeout("unexpected_bresp");
      end else begin
        logic [1:0] eb;
        eb = b_exp.pop_front();
        check("bresp", 32'(bus.bresp), 32'(eb));
      end
    end
    if (bus.rvalid && bus.rready) begin
      if (r_exp.size() == 0) begin
        timeout("unexpected_rdata");
      end else begin
        logic [45:0] er;
        er = r_exp.pop_front();
        check($sformatf("rdata@%h", er[45:34]), bus.rdata, er[33:2]);
        check($sformatf("rresp@%h", er[45:34]), 32'(bus.rresp), 32'(er[1:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_b();
    int n = 0;
    while (b_exp.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (b_exp.size() != 0) begin
      timeout("b_channel");
      b_exp.delete();
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er);
    int   n = 0;
    logic aw_ok, w_ok;
    b_exp.push_back(er);
    tick(1);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    while ((bus.awvalid || bus.wvalid) && n < 50) begin
      @(negedge clk);
      aw_ok = bus.awvalid && bus.awready;
      w_ok  = bus.wvalid && bus.wready;
      tick(1);
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok) bus.wvalid = 1'b0;
      n++;
    end
    if (n >= 50) begin
      timeout("aw_w_handshake");
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
    end
    wait_b();
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] er);
    int   n = 0;
    logic ar_ok = 1'b0;
    r_exp.push_back({a, d, er});
    tick(1);
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!ar_ok && n < 50) begin
      @(negedge clk);
      ar_ok = bus.arvalid && bus.arready;
      tick(1);
      n++;
    end
    bus.arvalid = 1'b0;
    if (!ar_ok) timeout("ar_handshake");
    n = 0;
    while (r_exp.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (r_exp.size() != 0) begin
      timeout("r_channel");
      r_exp.delete();
    end
  endtask

  task automatic pulse(input logic [1:0] m);
    tick(1);
    irq_src = m;
    tick(1);
    irq_src = '0;
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset state
    #12;
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_irq_out", 32'(irq_out), 0);
    tick(2);
    areset_n = 1'b1;
    for (int i = 0; i < 4; i++) axi_read(12'(4 * i), 0, OKAY);

    // Enabled pulse on source 1, exact irq_out latency, W1C
    axi_write(12'h004, 32'h3, 4'hF, OKAY);
    tick(1);
    irq_src = 2'b10;
    tick(1);
    irq_src = 2'b00;
    check("irq_out_edgeN", 32'(irq_out), 0);
    tick(1);
    check("irq_out_edgeN1", 32'(irq_out), 32'h2);
    axi_read(12'h000, 32'h2, OKAY);
    axi_read(12'h008, 32'h2, OKAY);
    axi_read(12'h014, 32'h1, OKAY);
    axi_write(12'h000, 32'h2, 4'hF, OKAY);
    tick(2);
    check("irq_out_after_w1c", 32'(irq_out), 0);

    // Masked latch, then late enable
    axi_write(12'h004, 32'h0, 4'hF, OKAY);
    pulse(2'b01);
    tick(2);
    axi_read(12'h000, 32'h1, OKAY);
    axi_read(12'h008, 32'h0, OKAY);
    check("irq_out_masked", 32'(irq_out), 0);
    axi_write(12'h004, 32'h1, 4'hF, OKAY);
    tick(1);
    check("irq_out_enabled", 32'(irq_out), 32'h1);
    axi_write(12'h004, 32'h0, 4'h0, OKAY);
    axi_read(12'h004, 32'h1, OKAY);

    // W1C and new rise on the same edge: set wins
    b_exp.push_back(OKAY);
    tick(1);
    bus.awaddr = 12'h000; bus.awvalid = 1'b1;
    bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(1);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    irq_src = 2'b01;
    tick(1);
    irq_src = 2'b00;
    wait_b();
    axi_read(12'h000, 32'h1, OKAY);
    axi_read(12'h010, 32'h2, OKAY);

    // Counter saturation and clear
    for (int i = 0; i < 300; i++) pulse(2'b01);
    axi_read(12'h010, 32'hFF, OKAY);
    axi_write(12'h010, 32'h0, 4'h0, OKAY);
    axi_read(12'h010, 32'h0, OKAY);
    axi_read(12'h014, 32'h1, OKAY);

    // Level mode: held source defeats W1C, counts once
    axi_write(12'h000, 32'h3, 4'hF, OKAY);
    axi_read(12'h000, 32'h0, OKAY);
    axi_write(12'h00C, 32'h1, 4'h1, OKAY);
    tick(1);
    irq_src = 2'b01;
    tick(3);
    axi_write(12'h000, 32'h1, 4'hF, OKAY);
    axi_read(12'h000, 32'h1, OKAY);
    axi_read(12'h010, 32'h1, OKAY);
    irq_src = 2'b00;
    tick(1);
    axi_write(12'h000, 32'h1, 4'hF, OKAY);
    axi_read(12'h000, 32'h0, OKAY);
    axi_write(12'h00C, 32'h0, 4'hF, OKAY);
    axi_read(12'h00C, 32'h0, OKAY);

    // Error responses
    axi_write(12'h008, 32'h3, 4'hF, SLVERR);
    axi_write(12'h018, 32'h3, 4'hF, SLVERR);
    axi_read(12'h018, 32'h0, SLVERR);

    // AW early, W late, B stalled, concurrent unmapped read
    bus.bready = 1'b0;
    b_exp.push_back(OKAY);
    tick(1);
    bus.awaddr = 12'h004; bus.awvalid = 1'b1;
    tick(1);
    bus.awvalid = 1'b0;
    check("awready_slot_full", 32'(bus.awready), 0);
    tick(2);
    bus.wdata = 32'h3; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick(1);
    bus.wvalid = 1'b0;
    axi_read(12'h040, 32'h0, SLVERR);
    check("bvalid_held", 32'(bus.bvalid), 1);
    tick(2);
    bus.bready = 1'b1;
    wait_b();
    axi_read(12'h004, 32'h3, OKAY);

    // Reset mid-transaction
    pulse(2'b10);
    tick(2);
    check("irq_out_pre_reset", 32'(irq_out), 32'h2);
    bus.awaddr = 12'h004; bus.awvalid = 1'b1;
    tick(1);
    bus.awvalid = 1'b0;
    areset_n = 1'b0;
    #1;
    check("mid_rst_awready", 32'(bus.awready), 0);
    check("mid_rst_bvalid", 32'(bus.bvalid), 0);
    check("mid_rst_irq_out", 32'(irq_out), 0);
    tick(2);
    areset_n = 1'b1;
    #1;
    check("post_rst_awready", 32'(bus.awready), 1);
    axi_read(12'h000, 32'h0, OKAY);
    axi_read(12'h004, 32'h0, OKAY);

    tick(3);
    if (b_exp.size() != 0 || r_exp.size() != 0) timeout("scoreboard_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
